// File: rtl/mops_cfg_sequencer_pkg.sv
// Shared constants for the MoPS configuration sequencer: shadow address map,
// CTRL field positions and FSM state encoding.
package mops_cfg_sequencer_pkg;

    localparam int WIDTH_BITS                  = 12;
    localparam int COMPATIBILITY_INTEGRAL_BITS = 16;

    localparam logic [3:0] ADDR_MIN0 = 4'd0;
    localparam logic [3:0] ADDR_MIN1 = 4'd1;
    localparam logic [3:0] ADDR_MIN2 = 4'd2;
    localparam logic [3:0] ADDR_MAX0 = 4'd3;
    localparam logic [3:0] ADDR_MAX1 = 4'd4;
    localparam logic [3:0] ADDR_MAX2 = 4'd5;
    localparam logic [3:0] ADDR_CTRL = 4'd6;
    localparam logic [3:0] ADDR_OCC  = 4'd7;
    localparam logic [3:0] ADDR_INT  = 4'd8;
    localparam logic [3:0] ADDR_OFS  = 4'd9;

    localparam int CTRL_TRIG_LSB = 0;
    localparam int CTRL_MULT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_PHASE = 2'd1,
        ST_SETTLE     = 2'd2
    } state_t;

endpackage

// File: rtl/mops_cfg_shadow.sv
// Shadow register bank: decodes software writes and stages them until the
// sequencer copies the whole set into the active registers.
module mops_cfg_shadow
    import mops_cfg_sequencer_pkg::*;
#(
    parameter int ADC_W = 12,
    parameter int OCC_W = 10,
    parameter int INT_W = 16,
    parameter int OFS_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_stb,
    input  logic [3:0]            wr_addr,
    input  logic [31:0]           wr_data,
    output logic [2:0][ADC_W-1:0] min_step,
    output logic [2:0][ADC_W-1:0] max_step,
    output logic [2:0]            trig_enable,
    output logic [1:0]            multiplicity,
    output logic [OCC_W-1:0]      occupancy,
    output logic [INT_W-1:0]      integral,
    output logic [OFS_W-1:0]      offset
);

    // Only the low bits of each write matter; the rest are deliberately dropped.
    logic unused_data;
    assign unused_data = ^wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_step     <= '0;
            max_step     <= '0;
            trig_enable  <= '0;
            multiplicity <= '0;
            occupancy    <= '1;
            integral     <= '1;
            offset       <= '0;
        end else if (wr_stb) begin
            case (wr_addr)
                ADDR_MIN0: min_step[0] <= wr_data[ADC_W-1:0];
                ADDR_MIN1: min_step[1] <= wr_data[ADC_W-1:0];
                ADDR_MIN2: min_step[2] <= wr_data[ADC_W-1:0];
                ADDR_MAX0: max_step[0] <= wr_data[ADC_W-1:0];
                ADDR_MAX1: max_step[1] <= wr_data[ADC_W-1:0];
                ADDR_MAX2: max_step[2] <= wr_data[ADC_W-1:0];
                ADDR_CTRL: begin
                    trig_enable  <= wr_data[CTRL_TRIG_LSB +: 3];
                    multiplicity <= wr_data[CTRL_MULT_LSB +: 2];
                end
                ADDR_OCC:  occupancy <= wr_data[OCC_W-1:0];
                ADDR_INT:  integral  <= wr_data[INT_W-1:0];
                ADDR_OFS:  offset    <= wr_data[OFS_W-1:0];
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/mops_cfg_sequencer.sv
// Applies the staged MoPS configuration atomically on a fixed 40 MHz phase,
// then holds trigger enable and multiplicity at zero for a settle interval.
module mops_cfg_sequencer
    import mops_cfg_sequencer_pkg::*;
#(
    parameter int         ADC_W        = 12,
    parameter int         OCC_W        = WIDTH_BITS - 2,
    parameter int         INT_W        = COMPATIBILITY_INTEGRAL_BITS,
    parameter int         OFS_W        = 4,
    parameter logic [1:0] APPLY_PHASE  = 2'd1,
    parameter int         SETTLE_TICKS = 122
) (
    input  logic             CLK120,
    input  logic             RESET,
    input  logic [1:0]       ENABLE40,
    input  logic             WR_STB,
    input  logic [3:0]       WR_ADDR,
    input  logic [31:0]      WR_DATA,
    input  logic             COMMIT,
    output logic             BUSY,
    output logic             APPLIED,
    output logic [ADC_W-1:0] MIN0,
    output logic [ADC_W-1:0] MIN1,
    output logic [ADC_W-1:0] MIN2,
    output logic [ADC_W-1:0] MAX0,
    output logic [ADC_W-1:0] MAX1,
    output logic [ADC_W-1:0] MAX2,
    output logic [2:0]       TRIG_ENABLE,
    output logic [OCC_W-1:0] OCCUPANCY,
    output logic [INT_W-1:0] INT,
    output logic [OFS_W-1:0] OFS,
    output logic [1:0]       MULTIPLICITY
);

    localparam int CNT_W = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_TICKS > 0) ? SETTLE_TICKS - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((SETTLE_TICKS > 0) ? SETTLE_TICKS : 0);

    logic [2:0][ADC_W-1:0] sh_min, sh_max, act_min, act_max;
    logic [2:0]            sh_trig, act_trig, trig_out;
    logic [1:0]            sh_mult, act_mult, mult_out;
    logic [OCC_W-1:0]      sh_occ, act_occ;
    logic [INT_W-1:0]      sh_int, act_int;
    logic [OFS_W-1:0]      sh_ofs, act_ofs;
    state_t                state;
    logic                  pending, busy, applied;
    logic [CNT_W-1:0]      settle_cnt;
    logic                  restart;

    mops_cfg_shadow #(
        .ADC_W(ADC_W), .OCC_W(OCC_W), .INT_W(INT_W), .OFS_W(OFS_W)
    ) shadow (
        .clk          (CLK120),
        .rst          (RESET),
        .wr_stb       (WR_STB),
        .wr_addr      (WR_ADDR),
        .wr_data      (WR_DATA),
        .min_step     (sh_min),
        .max_step     (sh_max),
        .trig_enable  (sh_trig),
        .multiplicity (sh_mult),
        .occupancy    (sh_occ),
        .integral     (sh_int),
        .offset       (sh_ofs)
    );

    // A commit seen in the same cycle we would return to IDLE counts as pending.
    assign restart = COMMIT | pending;

    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            busy       <= 1'b0;
            applied    <= 1'b0;
            settle_cnt <= '0;
            act_min    <= '0;
            act_max    <= '0;
            act_trig   <= '0;
            act_mult   <= '0;
            act_occ    <= '1;
            act_int    <= '1;
            act_ofs    <= '0;
            trig_out   <= '0;
            mult_out   <= '0;
        end else begin
            applied <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (COMMIT) begin
                        state    <= ST_WAIT_PHASE;
                        busy     <= 1'b1;
                        trig_out <= '0;
                        mult_out <= '0;
                    end
                end
                ST_WAIT_PHASE: begin
                    if (COMMIT) pending <= 1'b1;
                    if (ENABLE40 == APPLY_PHASE) begin
                        act_min    <= sh_min;
                        act_max    <= sh_max;
                        act_trig   <= sh_trig;
                        act_mult   <= sh_mult;
                        act_occ    <= sh_occ;
                        act_int    <= sh_int;
                        act_ofs    <= sh_ofs;
                        applied    <= 1'b1;
                        settle_cnt <= '0;
                        if (SETTLE_TICKS != 0) begin
                            state <= ST_SETTLE;
                        end else if (restart) begin
                            pending <= 1'b0;
                        end else begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            trig_out <= sh_trig;
                            mult_out <= sh_mult;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (COMMIT) pending <= 1'b1;
                    if (ENABLE40 == 2'd0) begin
                        if (settle_cnt != CNT_MAX) settle_cnt <= settle_cnt + 1'b1;
                        if (settle_cnt == CNT_LAST) begin
                            if (restart) begin
                                state   <= ST_WAIT_PHASE;
                                pending <= 1'b0;
                            end else begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                trig_out <= act_trig;
                                mult_out <= act_mult;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY         = busy;
    assign APPLIED      = applied;
    assign MIN0         = act_min[0];
    assign MIN1         = act_min[1];
    assign MIN2         = act_min[2];
    assign MAX0         = act_max[0];
    assign MAX1         = act_max[1];
    assign MAX2         = act_max[2];
    assign TRIG_ENABLE  = trig_out;
    assign MULTIPLICITY = mult_out;
    assign OCCUPANCY    = act_occ;
    assign INT          = act_int;
    assign OFS          = act_ofs;

endmodule
